// File: rtl/hack_pkg.sv
// hack_pkg: shared arbiter FSM state encoding and default Hack memory widths
package hack_pkg;
  localparam int HACK_AW = 15;
  localparam int HACK_DW = 16;
  typedef enum logic [2:0] {IDLE, CPU_RD, CPU_EX, HOST_IS, HOST_RSP} hack_state_e;
endpackage

// File: rtl/hack_mem_arb.sv
// hack_mem_arb: shares one SRAM between the Hack CPU data port and a host port; define HACK_ARB_STARVE_GUARD_EN to bound host bursts
module hack_mem_arb
  import hack_pkg::*;
#(
  parameter int AW = HACK_AW,
  parameter int DW = HACK_DW,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_en,
  output logic          mem_wren,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata
);
  hack_state_e state;
  logic [DW-1:0] cpu_rdata_q, host_rdata_q;
  logic starve;
  assign cpu_rdata = state == CPU_EX ? mem_rdata : cpu_rdata_q;
  assign host_rdata = state == HOST_RSP ? mem_rdata : host_rdata_q;
`ifdef HACK_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(HOST_BURST_MAX + 2);
  logic [CW-1:0] burst;
  assign starve = run && burst == CW'(HOST_BURST_MAX);
  // host grants since the last CPU step, saturating at the burst limit
  always_ff @(posedge clock)
    if (reset || state == CPU_EX) burst <= '0;
    else if (state == IDLE && host_req && !starve && burst != CW'(HOST_BURST_MAX)) burst <= burst + 1'b1;
`else
  assign starve = 1'b0;
`endif
  // arbiter FSM; strobes and SRAM port are registered so they line up with the state they belong to
  always_ff @(posedge clock) begin
    cpu_en <= 1'b0;
    host_ack <= 1'b0;
    host_rvalid <= 1'b0;
    mem_wren <= 1'b0;
    if (reset) begin
      state <= IDLE;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_rdata_q <= '0;
      host_rdata_q <= '0;
    end else case (state)
      IDLE:
        if (host_req && !starve) begin
          state <= HOST_IS;
          if (host_we) begin
            mem_wren <= 1'b1;
            mem_waddr <= host_addr;
            mem_wdata <= host_wdata;
            host_ack <= 1'b1;
          end else mem_raddr <= host_addr;
        end else if (run) begin
          state <= CPU_RD;
          mem_raddr <= cpu_addr;
        end
      CPU_RD: begin
        state <= CPU_EX;
        cpu_en <= 1'b1;
        if (cpu_we) begin
          mem_wren <= 1'b1;
          mem_waddr <= cpu_addr;
          mem_wdata <= cpu_wdata;
        end
      end
      CPU_EX: begin
        state <= IDLE;
        cpu_rdata_q <= mem_rdata;
      end
      HOST_IS:
        if (mem_wren) state <= IDLE;
        else begin
          state <= HOST_RSP;
          host_ack <= 1'b1;
          host_rvalid <= 1'b1;
        end
      HOST_RSP: begin
        state <= IDLE;
        host_rdata_q <= mem_rdata;
      end
      default: state <= IDLE;
    endcase
  end
endmodule

// File: tb/tb_hack_mem_arb.sv
// tb_hack_mem_arb: table vectors, directed corner sequences and a randomized run against a memory-level model
module tb_hack_mem_arb;
  logic clock, reset, run, host_req, host_we, host_ack, host_rvalid, cpu_we, cpu_en, mem_wren;
  logic [14:0] host_addr, cpu_addr, mem_waddr, mem_raddr;
  logic [15:0] host_wdata, host_rdata, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem [0:32767];
  logic [15:0] ref_mem [0:15];
  logic [15:0] last_cpu, last_host, d;
  int n_chk, n_err, n_ack, n_cpu, since, pend, wait_n;
`ifdef HACK_ARB_STARVE_GUARD_EN
  localparam int LAT_MAX = 6;
`else
  localparam int LAT_MAX = 5;
`endif
  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [15:0] data;
    logic [3:0]  lat;
    logic [15:0] rdata;
  } vec_t;
  vec_t tbl [0:7];

  hack_mem_arb dut (
    .clock(clock), .reset(reset), .run(run),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_en(cpu_en),
    .mem_wren(mem_wren), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_ctrl"}, 32'({cpu_en, host_ack, host_rvalid, mem_wren}), 0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
    check({tag, "_host_rdata"}, 32'(host_rdata), 0);
    check({tag, "_mem_raddr"}, 32'(mem_raddr), 0);
    check({tag, "_mem_waddr"}, 32'(mem_waddr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // one host access starting in an idle cycle; latency counts the request cycle as 1
  task automatic host_op(input logic we, input logic [14:0] a, input logic [15:0] wd, input int lat, input logic [15:0] rd);
    int n;
    host_req = 1'b1;
    host_we = we;
    host_addr = a;
    host_wdata = wd;
    n = 1;
    do begin
      @(negedge clock);
      n++;
    end while (!host_ack && n < 12);
    check("host_lat", n, lat);
    if (we) begin
      check("host_wr_wren", 32'(mem_wren), 1);
      check("host_wr_waddr", 32'(mem_waddr), 32'(a));
      check("host_wr_wdata", 32'(mem_wdata), 32'(wd));
      check("host_wr_rvalid", 32'(host_rvalid), 0);
    end else begin
      check("host_rd_rvalid", 32'(host_rvalid), 1);
      check("host_rd_data", 32'(host_rdata), 32'(rd));
      check("host_rd_wren", 32'(mem_wren), 0);
    end
    host_req = 1'b0;
    @(negedge clock);
    check("host_ack_pulse", 32'(host_ack), 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 15'h0010, 16'hBEEF, 4'd2, 16'h0000};
    tbl[1] = '{1'b0, 15'h0010, 16'h0000, 4'd3, 16'hBEEF};
    tbl[2] = '{1'b1, 15'h7FFF, 16'hFFFF, 4'd2, 16'h0000};
    tbl[3] = '{1'b0, 15'h7FFF, 16'h0000, 4'd3, 16'hFFFF};
    tbl[4] = '{1'b1, 15'h0000, 16'h0001, 4'd2, 16'h0000};
    tbl[5] = '{1'b0, 15'h0000, 16'h0000, 4'd3, 16'h0001};
    tbl[6] = '{1'b0, 15'h0010, 16'h0000, 4'd3, 16'hBEEF};
    tbl[7] = '{1'b0, 15'h0005, 16'h0000, 4'd3, 16'h1234};
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    run = 1'b0;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_we = 1'b0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    // CPU stepping alone: one step every third cycle, read data held between steps
    host_op(1'b1, 15'h0005, 16'h1234, 2, 16'h0);
    cpu_addr = 15'h0005;
    cpu_we = 1'b0;
    run = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      check("cpu_period", 32'(cpu_en), 32'(i % 3 == 2));
      check("cpu_rdata", 32'(cpu_rdata), i >= 2 ? 32'h1234 : 32'h0);
      check("cpu_rd_nowren", 32'(mem_wren), 0);
    end
    // host request arriving in CPU_RD waits for the CPU write; run dropping there does not cancel it
    cpu_we = 1'b1;
    cpu_addr = 15'h0020;
    cpu_wdata = 16'hA5A5;
    @(negedge clock);
    check("mid_rd_cpu_en", 32'(cpu_en), 0);
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 15'h0021;
    host_wdata = 16'h5A5A;
    run = 1'b0;
    @(negedge clock);
    check("mid_ex_cpu_en", 32'(cpu_en), 1);
    check("mid_ex_ack", 32'(host_ack), 0);
    check("mid_ex_wren", 32'(mem_wren), 1);
    check("mid_ex_waddr", 32'(mem_waddr), 32'h20);
    check("mid_ex_wdata", 32'(mem_wdata), 32'hA5A5);
    @(negedge clock);
    check("mid_idle_ack", 32'(host_ack), 0);
    check("mid_idle_wren", 32'(mem_wren), 0);
    @(negedge clock);
    check("mid_host_ack", 32'(host_ack), 1);
    check("mid_host_cpu_en", 32'(cpu_en), 0);
    check("mid_host_waddr", 32'(mem_waddr), 32'h21);
    check("mid_host_wdata", 32'(mem_wdata), 32'h5A5A);
    host_req = 1'b0;
    cpu_we = 1'b0;
    @(negedge clock);
    host_op(1'b0, 15'h0020, 16'h0, 3, 16'hA5A5);
    host_op(1'b0, 15'h0021, 16'h0, 3, 16'h5A5A);
    for (int i = 0; i < 8; i++) host_op(tbl[i].we, tbl[i].addr, tbl[i].data, int'(tbl[i].lat), tbl[i].rdata);
    // reset during a host read issue aborts it
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 15'h0010;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("rst_host");
    reset = 1'b0;
    host_req = 1'b0;
    @(negedge clock);
    check("rst_host_rvalid", 32'(host_rvalid), 0);
    check("rst_host_ack", 32'(host_ack), 0);
    host_op(1'b1, 15'h0011, 16'h1111, 2, 16'h0);
    // reset during CPU_RD aborts the step and its write
    cpu_addr = 15'h0005;
    cpu_we = 1'b1;
    cpu_wdata = 16'hDEAD;
    run = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("rst_cpu");
    reset = 1'b0;
    run = 1'b0;
    cpu_we = 1'b0;
    @(negedge clock);
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_cpu_wren", 32'(mem_wren), 0);
    host_op(1'b0, 15'h0005, 16'h0, 3, 16'h1234);
    // continuous host writes with run high
    do_reset();
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 15'h0030;
    host_wdata = 16'h0F0F;
    run = 1'b1;
    n_ack = 0;
    n_cpu = 0;
    since = 0;
    for (int i = 0; i < 66; i++) begin
      @(negedge clock);
      check("burst_one_writer", 32'(cpu_en & host_ack), 0);
      if (host_ack) begin
        n_ack++;
        since++;
      end
      if (cpu_en) begin
        n_cpu++;
        check("burst_acks_per_step", since, 4);
        since = 0;
      end
    end
    host_req = 1'b0;
    run = 1'b0;
    repeat (4) @(negedge clock);
`ifdef HACK_ARB_STARVE_GUARD_EN
    check("guard_steps", n_cpu, 6);
    check("guard_acks", n_ack, 24);
`else
    check("starve_steps", n_cpu, 0);
    check("starve_acks", n_ack, 33);
`endif
    // randomized traffic against a word-level memory model
    do_reset();
    last_cpu = '0;
    last_host = '0;
    for (int k = 0; k < 16; k++) begin
      d = 16'($urandom);
      ref_mem[k] = d;
      host_op(1'b1, 15'h0100 + 15'(k), d, 2, 16'h0);
    end
    cpu_addr = 15'h0100 + 15'($urandom_range(0, 15));
    cpu_we = 1'($urandom);
    cpu_wdata = 16'($urandom);
    run = 1'b1;
    pend = 0;
    wait_n = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      if (pend != 0) wait_n++;
      check("rnd_one_writer", 32'(cpu_en & host_ack), 0);
      if (cpu_en) begin
        last_cpu = ref_mem[cpu_addr[3:0]];
        check("rnd_cpu_rdata", 32'(cpu_rdata), 32'(last_cpu));
        check("rnd_cpu_wren", 32'(mem_wren), 32'(cpu_we));
        if (cpu_we) begin
          check("rnd_cpu_waddr", 32'(mem_waddr), 32'(cpu_addr));
          check("rnd_cpu_wdata", 32'(mem_wdata), 32'(cpu_wdata));
          ref_mem[cpu_addr[3:0]] = cpu_wdata;
        end
        cpu_addr = 15'h0100 + 15'($urandom_range(0, 15));
        cpu_we = 1'($urandom);
        cpu_wdata = 16'($urandom);
      end else check("rnd_cpu_hold", 32'(cpu_rdata), 32'(last_cpu));
      if (host_ack) begin
        check("rnd_ack_pending", pend, 1);
        check("rnd_host_lat", 32'(wait_n <= LAT_MAX), 1);
        if (host_we) begin
          check("rnd_host_rvalid", 32'(host_rvalid), 0);
          check("rnd_host_wren", 32'(mem_wren), 1);
          check("rnd_host_waddr", 32'(mem_waddr), 32'(host_addr));
          check("rnd_host_wdata", 32'(mem_wdata), 32'(host_wdata));
          ref_mem[host_addr[3:0]] = host_wdata;
        end else begin
          last_host = ref_mem[host_addr[3:0]];
          check("rnd_host_rvalid", 32'(host_rvalid), 1);
          check("rnd_host_rdata", 32'(host_rdata), 32'(last_host));
        end
        pend = 0;
        host_req = 1'b0;
      end else begin
        check("rnd_host_hold", 32'(host_rdata), 32'(last_host));
        check("rnd_rvalid_idle", 32'(host_rvalid), 0);
        if (!cpu_en) check("rnd_wren_idle", 32'(mem_wren), 0);
        if (pend != 0 && wait_n > LAT_MAX) begin
          check("rnd_host_timeout", wait_n, LAT_MAX);
          pend = 0;
          host_req = 1'b0;
        end
      end
      run = $urandom_range(0, 9) != 0;
      if (pend == 0 && !host_ack && $urandom_range(0, 2) == 0) begin
        host_req = 1'b1;
        host_we = 1'($urandom);
        host_addr = 15'h0100 + 15'($urandom_range(0, 15));
        host_wdata = 16'($urandom);
        pend = 1;
        wait_n = 1;
      end
    end
    host_req = 1'b0;
    run = 1'b0;
    repeat (4) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
